// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// ----------------
// Receive-side decoder for a six-digit multiplexed seven-segment bus. The
// active-low one-hot digit select (sel) and active-low segments (dig) are
// registered once. Once a valid select has been stable long enough, the
// segment pattern is decoded into a 4-bit code and a dot flag for that slot.
// When all six slots have been seen, the assembled frame is published.
//
// Build option: define SEG_DEC_STALL_EN to build the scan-stall detector.
// Without it, scan_stall is tied low and TIMEOUT has no effect.
//
// Parameters:
//   SETTLE_CYC  cycles sel_q must be stable before dig_q is sampled (2..255)
//   TIMEOUT     cycles without a sel_q change before scan_stall asserts
//
// Ports:
//   clk          single clock
//   rst          synchronous reset, active-high
//   sel[5:0]     digit select, active-low one-hot (sel[5] low = slot 0)
//   dig[7:0]     segments, active-low; dig[7] = dot, dig[6:0] = g..a
//   digits[23:0] recovered frame; slot n is digits[4n+3:4n]
//   dot_on[5:0]  active-high dot per slot
//   frame_valid  one-cycle strobe when digits/dot_on update. There is no
//                ready input: consumers must capture on the strobe.
//   code_err     sticky: an unknown segment pattern was sampled
//   sel_err      sticky: a sel value without exactly one low bit was seen
//   scan_stall   level: sel has been frozen for TIMEOUT cycles

module seg_scan_decoder #(
  parameter int SETTLE_CYC = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  sel,
  input  logic [7:0]  dig,
  output logic [23:0] digits,
  output logic [5:0]  dot_on,
  output logic        frame_valid,
  output logic        code_err,
  output logic        sel_err,
  output logic        scan_stall
);

  // The settle counter reaches SAMPLE_AT in the cycle before edge
  // t0+SETTLE_CYC: it is cleared at t0+1 (the change-detect cycle), and
  // then counts up once per edge. It then parks at SAT, which means
  // "already sampled in this dwell".
  localparam logic [7:0] SAMPLE_AT = 8'(SETTLE_CYC - 2);
  localparam logic [7:0] SAT       = 8'(SETTLE_CYC - 1);

  logic [5:0]  sel_q;
  logic [5:0]  sel_prev;
  logic [7:0]  dig_q;
  logic        in_vld;      // sel_q holds a real input, not its reset value
  logic [7:0]  settle_cnt;
  logic [5:0]  seen;
  logic [23:0] shadow;
  logic [5:0]  shadow_dot;

  logic        sel_chg;
  logic        slot_vld;
  logic [2:0]  slot_idx;
  logic [3:0]  code;
  logic        code_bad;
  logic        sample_now;
  logic [5:0]  seen_nxt;
  logic [23:0] shadow_nxt;
  logic [5:0]  dot_nxt;
  logic        frame_done;

  assign sel_chg = (sel_q != sel_prev);

  // Slot map: exactly one low bit. Anything else is an invalid select.
  always_comb begin
    slot_vld = 1'b1;
    slot_idx = 3'd0;
    case (sel_q)
      6'b011111: slot_idx = 3'd0;
      6'b101111: slot_idx = 3'd1;
      6'b110111: slot_idx = 3'd2;
      6'b111011: slot_idx = 3'd3;
      6'b111101: slot_idx = 3'd4;
      6'b111110: slot_idx = 3'd5;
      default:   slot_vld = 1'b0;
    endcase
  end

  // Segment decode, active-low g..a. All segments off is a blank (F).
  always_comb begin
    code_bad = 1'b0;
    code     = 4'hE;
    case (dig_q[6:0])
      7'b1000000: code = 4'h0;
      7'b1111001: code = 4'h1;
      7'b0100100: code = 4'h2;
      7'b0110000: code = 4'h3;
      7'b0011001: code = 4'h4;
      7'b0010010: code = 4'h5;
      7'b0000010: code = 4'h6;
      7'b1111000: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0010000: code = 4'h9;
      7'b0001111: code = 4'hA;
      7'b0111111: code = 4'hB;
      7'b1111111: code = 4'hF;
      default:    code_bad = 1'b1;
    endcase
  end

  assign sample_now = slot_vld && !sel_chg && (settle_cnt == SAMPLE_AT);
  assign seen_nxt   = seen | (6'b000001 << slot_idx);
  assign frame_done = sample_now && (seen_nxt == 6'h3F);

  // Shadow contents including this cycle's sample, so a completing sample
  // lands in the published frame without an extra cycle.
  always_comb begin
    shadow_nxt = shadow;
    dot_nxt    = shadow_dot;
    if (sample_now) begin
      shadow_nxt[{slot_idx, 2'b00} +: 4] = code;
      dot_nxt[slot_idx]                  = ~dig_q[7];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= 6'h3F;
      sel_prev    <= 6'h3F;
      dig_q       <= 8'hFF;
      in_vld      <= 1'b0;
      settle_cnt  <= 8'd0;
      seen        <= 6'd0;
      shadow      <= 24'hFFFFFF;
      shadow_dot  <= 6'd0;
      digits      <= 24'hFFFFFF;
      dot_on      <= 6'd0;
      frame_valid <= 1'b0;
      code_err    <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      sel_q       <= sel;
      sel_prev    <= sel_q;
      dig_q       <= dig;
      in_vld      <= 1'b1;
      frame_valid <= frame_done;

      // A new dwell (or an invalid select) restarts the count.
      if (sel_chg || !slot_vld) begin
        settle_cnt <= 8'd0;
      end else if (settle_cnt != SAT) begin
        settle_cnt <= settle_cnt + 8'd1;
      end

      if (in_vld && !slot_vld) begin
        sel_err <= 1'b1;
      end
      if (sample_now && code_bad) begin
        code_err <= 1'b1;
      end

      shadow     <= shadow_nxt;
      shadow_dot <= dot_nxt;

      if (frame_done) begin
        digits <= shadow_nxt;
        dot_on <= dot_nxt;
        seen   <= 6'd0;
      end else if (sample_now) begin
        seen <= seen_nxt;
      end
    end
  end

`ifdef SEG_DEC_STALL_EN
  localparam int STW = $clog2(TIMEOUT + 1);

  logic [STW-1:0] stall_cnt;

  // sel != sel_q means sel_q changes on this edge, so the stall clears on
  // the same edge that registers the new select.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      scan_stall <= 1'b0;
    end else if (sel != sel_q) begin
      stall_cnt  <= '0;
      scan_stall <= 1'b0;
    end else if (stall_cnt != STW'(TIMEOUT)) begin
      stall_cnt <= stall_cnt + 1'b1;
      if (stall_cnt == STW'(TIMEOUT - 1)) begin
        scan_stall <= 1'b1;
      end
    end
  end
`else
  // Folds to constant 0; TIMEOUT is referenced only so it stays in use.
  assign scan_stall = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with hand-computed expected frames.

module tb_seg_scan_decoder;

  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 4096;

`ifdef SEG_DEC_STALL_EN
  localparam logic STALL_EN = 1'b1;
`else
  localparam logic STALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  sel;
  logic [7:0]  dig;
  logic [23:0] digits;
  logic [5:0]  dot_on;
  logic        frame_valid;
  logic        code_err;
  logic        sel_err;
  logic        scan_stall;

  int n_checks = 0;
  int n_fail   = 0;
  int fv_cnt   = 0;
  int base;

  seg_scan_decoder #(
    .SETTLE_CYC (SETTLE),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sel         (sel),
    .dig         (dig),
    .digits      (digits),
    .dot_on      (dot_on),
    .frame_valid (frame_valid),
    .code_err    (code_err),
    .sel_err     (sel_err),
    .scan_stall  (scan_stall)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  // Counts high cycles of frame_valid, so a stretched pulse shows up too.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt++;
  end

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Active-low bus pattern for a code, with optional dot.
  function automatic logic [7:0] pat(input logic [3:0] code, input logic dot);
    logic [6:0] s;
    case (code)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001111;
      4'hB:    s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return {~dot, s};
  endfunction

  // Driver tasks: inputs change 1 time unit after a rising edge.
  task automatic dwell(input int slot, input logic [7:0] d, input int n);
    sel = ~(6'b100000 >> slot);
    dig = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [23:0] codes, input logic [5:0] dots, input int n);
    for (int s = 0; s < 6; s++) begin
      dwell(s, pat(codes[4*s +: 4], dots[s]), n);
    end
  endtask

  initial begin
    rst = 1'b1;
    sel = 6'b011111;
    dig = pat(4'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_digits", digits, 24'hFFFFFF);
    check("rst_dot_on", {18'd0, dot_on}, 24'd0);
    check("rst_frame_valid", {23'd0, frame_valid}, 24'd0);
    check("rst_code_err", {23'd0, code_err}, 24'd0);
    check("rst_sel_err", {23'd0, sel_err}, 24'd0);
    check("rst_scan_stall", {23'd0, scan_stall}, 24'd0);
    rst = 1'b0;

    // Clean frame 0..5, long dwells
    base = fv_cnt;
    frame(24'h543210, 6'b000000, 1000);
    check("f1_pulses", 24'(fv_cnt - base), 24'd1);
    check("f1_digits", digits, 24'h543210);
    check("f1_dot_on", {18'd0, dot_on}, 24'd0);
    check("f1_code_err", {23'd0, code_err}, 24'd0);
    check("f1_sel_err", {23'd0, sel_err}, 24'd0);

    // Dot on slot 2
    base = fv_cnt;
    frame(24'h543210, 6'b000100, 20);
    check("f2_pulses", 24'(fv_cnt - base), 24'd1);
    check("f2_digits", digits, 24'h543210);
    check("f2_dot_on", {18'd0, dot_on}, 24'h000004);

    // Unknown pattern on slot 3
    base = fv_cnt;
    dwell(0, pat(4'h0, 1'b0), 20);
    dwell(1, pat(4'h1, 1'b0), 20);
    dwell(2, pat(4'h2, 1'b0), 20);
    dwell(3, 8'hD5, 20);
    dwell(4, pat(4'h4, 1'b0), 20);
    dwell(5, pat(4'h5, 1'b0), 20);
    check("f3_pulses", 24'(fv_cnt - base), 24'd1);
    check("f3_digits", digits, 24'h54E210);
    check("f3_code_err", {23'd0, code_err}, 24'd1);
    check("f3_dot_on", {18'd0, dot_on}, 24'd0);

    // Clean frame afterwards: data recovers, code_err stays set
    frame(24'h543210, 6'b000000, 20);
    check("f4_digits", digits, 24'h543210);
    check("f4_code_err", {23'd0, code_err}, 24'd1);
    check("f4_sel_err", {23'd0, sel_err}, 24'd0);

    // Short slot-1 glitch then an invalid select
    base = fv_cnt;
    dwell(1, pat(4'h1, 1'b0), SETTLE - 2);
    sel = 6'b001111;
    repeat (10) @(posedge clk);
    #1;
    check("glitch_sel_err", {23'd0, sel_err}, 24'd1);
    dwell(0, pat(4'h7, 1'b0), 20);
    dwell(2, pat(4'h7, 1'b0), 20);
    dwell(3, pat(4'h7, 1'b0), 20);
    dwell(4, pat(4'h7, 1'b0), 20);
    dwell(5, pat(4'h7, 1'b0), 20);
    check("glitch_no_frame", 24'(fv_cnt - base), 24'd0);
    dwell(1, pat(4'h9, 1'b0), 20);
    check("glitch_pulses", 24'(fv_cnt - base), 24'd1);
    check("glitch_digits", digits, 24'h777797);
    check("glitch_sel_err_sticky", {23'd0, sel_err}, 24'd1);

    // Frozen select
    sel = 6'b011111;
    dig = pat(4'h0, 1'b0);
    repeat (TIMEOUT) @(posedge clk);
    #1;
    check("stall_before", {23'd0, scan_stall}, 24'd0);
    @(posedge clk);
    #1;
    check("stall_at_timeout", {23'd0, scan_stall}, {23'd0, STALL_EN});
    repeat (5000 - TIMEOUT - 1) @(posedge clk);
    #1;
    check("stall_held", {23'd0, scan_stall}, {23'd0, STALL_EN});
    sel = 6'b101111;
    @(posedge clk);
    #1;
    check("stall_cleared", {23'd0, scan_stall}, 24'd0);
    repeat (20) @(posedge clk);
    #1;

    // Reset after four slots discards the partial frame
    dwell(0, pat(4'h3, 1'b0), 20);
    dwell(1, pat(4'h3, 1'b0), 20);
    dwell(2, pat(4'h3, 1'b0), 20);
    dwell(3, pat(4'h3, 1'b0), 20);
    sel = 6'b011111;
    dig = pat(4'hB, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst2_digits", digits, 24'hFFFFFF);
    check("rst2_code_err", {23'd0, code_err}, 24'd0);
    check("rst2_sel_err", {23'd0, sel_err}, 24'd0);
    rst = 1'b0;
    base = fv_cnt;
    for (int s = 0; s < 5; s++) begin
      dwell(s, pat(4'hB, 1'b0), 20);
    end
    check("rst2_no_early_frame", 24'(fv_cnt - base), 24'd0);
    dwell(5, pat(4'hB, 1'b0), 20);
    check("rst2_pulses", 24'(fv_cnt - base), 24'd1);
    check("rst2_frame_digits", digits, 24'hBBBBBB);
    check("rst2_frame_dot_on", {18'd0, dot_on}, 24'd0);
    check("rst2_frame_sel_err", {23'd0, sel_err}, 24'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
